// File: rtl/sdi_rx_axil_regs.sv
// AXI4-Lite slave holding the four SDI RX control registers (CTRL, FORMAT, LINE_CFG, SCRATCH).
// Optional build macro SDI_RX_REGS_WSTRB_EN enables per-byte write strobes; otherwise writes are full-word.
module sdi_rx_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]                      AWPROT,
    input  logic                            AWVALID,
    output logic                            AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                            WVALID,
    output logic                            WREADY,
    output logic [1:0]                      BRESP,
    output logic                            BVALID,
    input  logic                            BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]                      ARPROT,
    input  logic                            ARVALID,
    output logic                            ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                      RRESP,
    output logic                            RVALID,
    input  logic                            RREADY,
    output logic [127:0]                    reg_o,
    output logic [3:0]                      reg_wr_pulse_o
);

    logic [31:0] regs_r [4];
    logic        awready_r;
    logic        bvalid_r;
    logic [3:0]  wr_pulse_r;
    logic        arready_r;
    logic        rvalid_r;
    logic [31:0] rdata_r;

    logic        wr_start_s;
    logic        wr_fire_s;
    logic [1:0]  wr_idx_s;
    logic [31:0] wr_data_s;
    logic        rd_start_s;
    logic        rd_fire_s;
    logic [1:0]  rd_idx_s;
    logic        unused_s;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int k = 0; k < 4; k++) begin
            res[8*k +: 8] = strb[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
        end
        return res;
    endfunction

    // A single ready cycle is raised only once both halves of a write are present and no response is pending.
    assign wr_start_s = AWVALID && WVALID && !bvalid_r && !awready_r;
    assign wr_fire_s  = awready_r && AWVALID && WVALID;
    assign wr_idx_s   = AWADDR[3:2];
    assign rd_start_s = ARVALID && !rvalid_r && !arready_r;
    assign rd_fire_s  = arready_r && ARVALID;
    assign rd_idx_s   = ARADDR[3:2];

    // Merge incoming write data with the current register contents.
    always_comb begin
        wr_data_s = 32'h0000_0000;
`ifdef SDI_RX_REGS_WSTRB_EN
        wr_data_s = apply_wstrb(regs_r[wr_idx_s], WDATA[31:0], WSTRB[3:0]);
`else
        wr_data_s = WDATA[31:0];
`endif
    end

`ifdef SDI_RX_REGS_WSTRB_EN
    assign unused_s = &{1'b0, AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};
`else
    assign unused_s = &{1'b0, AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0], WSTRB};
`endif

    // Write channel: ready pulse, register update, write strobe and B response.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            for (int i = 0; i < 4; i++) begin
                regs_r[i] <= 32'h0000_0000;
            end
            awready_r  <= 1'b0;
            bvalid_r   <= 1'b0;
            wr_pulse_r <= 4'b0000;
        end else begin
            awready_r  <= wr_start_s;
            wr_pulse_r <= 4'b0000;
            if (wr_fire_s) begin
                regs_r[wr_idx_s]     <= wr_data_s;
                wr_pulse_r[wr_idx_s] <= 1'b1;
                bvalid_r             <= 1'b1;
            end else if (bvalid_r && BREADY) begin
                bvalid_r <= 1'b0;
            end else begin
                bvalid_r <= bvalid_r;
            end
        end
    end

    // Read channel: the register is sampled on the handshake edge, so a same-edge write is not yet visible.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'h0000_0000;
        end else begin
            arready_r <= rd_start_s;
            if (rd_fire_s) begin
                rvalid_r <= 1'b1;
                rdata_r  <= regs_r[rd_idx_s];
            end else if (rvalid_r && RREADY) begin
                rvalid_r <= 1'b0;
            end else begin
                rvalid_r <= rvalid_r;
            end
        end
    end

    assign AWREADY        = awready_r;
    assign WREADY         = awready_r;
    assign BVALID         = bvalid_r;
    assign BRESP          = 2'b00;
    assign ARREADY        = arready_r;
    assign RVALID         = rvalid_r;
    assign RDATA          = rdata_r;
    assign RRESP          = 2'b00;
    assign reg_wr_pulse_o = wr_pulse_r;
    assign reg_o          = {regs_r[3], regs_r[2], regs_r[1], regs_r[0]};

endmodule

// File: doc/sdi_rx_axil_regs.md
SDI_RX_AXIL_REGS -- requirements
Module: sdi_rx_axil_regs

Interface
REQ-001 The block SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-002 The block SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, AXI4-Lite address width; addr[3:2] selects one of 4 registers.
REQ-003 The block SHALL have port ACLK, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 The block SHALL have port ARESETN, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have ports AWADDR in 4, AWPROT in 3, AWVALID in 1 and AWREADY out 1: write address channel; AWPROT is ignored.
REQ-006 The block SHALL have ports WDATA in 32, WSTRB in 4, WVALID in 1 and WREADY out 1: write data channel.
REQ-007 The block SHALL have ports BRESP out 2, BVALID out 1 and BREADY in 1: write response channel.
REQ-008 The block SHALL have ports ARADDR in 4, ARPROT in 3, ARVALID in 1 and ARREADY out 1: read address channel; ARPROT is ignored.
REQ-009 The block SHALL have ports RDATA out 32, RRESP out 2, RVALID out 1 and RREADY in 1: read data channel.
REQ-010 The block SHALL have port reg_o, output, 128 bits: register contents, reg N at bits [32N+31:32N], towards the SDI RX datapath.
REQ-011 The block SHALL have port reg_wr_pulse_o, output, 4 bits: bit N high for exactly one cycle after reg N is written.

Function
REQ-012 Register map SHALL be 0x0 CTRL, 0x4 FORMAT, 0x8 LINE_CFG and 0xC SCRATCH; all four are read/write, 32 bits, and their reset value is 0.
REQ-013 addr[1:0] SHALL be ignored; no address decodes to an error.
REQ-014 A write SHALL be accepted only in a cycle where AWVALID=1, WVALID=1, BVALID=0 and AWREADY=0; in that case AWREADY and WREADY are both driven high for exactly that one cycle.
REQ-015 AWVALID or WVALID arriving alone SHALL wait with READY low; either order of arrival is legal.
REQ-016 The addressed register SHALL update on the acceptance edge, with reg_o reflecting the new value on the next cycle.
REQ-017 reg_wr_pulse_o[N] SHALL be high in the cycle after acceptance, for one cycle only.
REQ-018 BVALID SHALL rise in the cycle after acceptance with BRESP=2'b00, and hold until BREADY=1; it clears on that edge.
REQ-019 No new write SHALL be accepted while BVALID=1, so at most one write is outstanding.
REQ-020 ARREADY SHALL pulse high for one cycle when ARVALID=1, RVALID=0 and ARREADY=0.
REQ-021 RVALID SHALL rise in the cycle after ARREADY with RDATA set to the addressed register and RRESP=2'b00.
REQ-022 RDATA and RVALID SHALL be held stable until RREADY=1; RVALID clears on that edge.
REQ-023 At most one read SHALL be outstanding.
REQ-024 Read and write channels SHALL be independent; a simultaneous read and write to the same register returns the pre-write value.
REQ-025 BVALID and RVALID backpressure of any length SHALL lose no data and accept no extra transaction.

Reset
REQ-026 While ARESETN=0 at a clock edge, all registers, reg_o, reg_wr_pulse_o, AWREADY, WREADY, ARREADY, BVALID and RVALID SHALL be 0, and BRESP, RRESP and RDATA SHALL be 0.
REQ-027 Reset asserted mid-transaction SHALL abandon it; after release the block accepts no transaction until a fresh VALID is seen, and no response is issued for an abandoned transaction.

Configuration
REQ-028 With macro SDI_RX_REGS_WSTRB_EN defined, WSTRB[k] SHALL gate write of byte k; WSTRB=0 leaves the register unchanged but still pulses reg_wr_pulse_o and returns BVALID.
REQ-029 Without SDI_RX_REGS_WSTRB_EN, WSTRB SHALL be ignored and every accepted write replaces all 32 bits.

Verification
REQ-030 The bench SHALL cover: write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read back -> RDATA 0x1..0x4, all RESP=OKAY, reg_o=0x00000004_00000003_00000002_00000001.
REQ-031 The bench SHALL cover: WVALID asserted 3 cycles before AWVALID, write 0xA5A5A5A5 to 0x8 -> AWREADY and WREADY rise together once, reg_wr_pulse_o=4'b0100 for one cycle.
REQ-032 The bench SHALL cover: BREADY held low 10 cycles while a second write is offered -> BVALID stays high and the second write is accepted only after the first B handshake.
REQ-033 The bench SHALL cover: with WSTRB_EN, reg0=0xFFFFFFFF, write 0x12345678 with WSTRB=4'b0101 -> read 0xFF34FF78; without the macro -> read 0x12345678.
REQ-034 The bench SHALL cover: simultaneous write 0xDEADBEEF and read of 0xC, which held 0x4 -> RDATA=0x4, and a subsequent read -> 0xDEADBEEF.
REQ-035 The bench SHALL cover: ARESETN low for one cycle while RVALID is pending -> RVALID=0 next cycle, all registers read 0 afterwards.
